fpu_sched: RTL

- Two-requester scheduler that shares the single floating-point unit (`fpu`) between independent clients.
- Arbitrates requests round-robin and captures the winner's op/A/B.
- Pulses the FPU's own reset, then holds its start line until `done` or a timeout.
- Returns the result with a per-requester done pulse. Sits between client FSMs and the `fpu` instance.

---
 rtl/fpu_sched_pkg.sv | 15 +
 rtl/fpu_rr_arb2.sv | 22 ++
 rtl/fpu_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared encodings for the FPU scheduler: FSM states and the canned
// quiet-NaN answer used for illegal ops and timeouts.
package fpu_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CLR  = 2'd1,
      S_RUN  = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic [31:0] QNAN       = 32'h7FC0_0000;
   localparam logic [1:0]  OP_ILLEGAL = 2'b11;

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin arbiter: rr selects the winner only when both request.
module fpu_rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic rr,
   output logic id,
   output logic valid
);

   // Pick the winner; with a tie the rr pointer decides.
   always_comb begin
      valid = req0 | req1;
      if (req0 && req1) begin
         id = rr;
      end else if (req1) begin
         id = 1'b1;
      end else begin
         id = 1'b0;
      end
   end

endmodule

// File: rtl/fpu_sched.sv
// Shares one FPU between two clients: arbitrate, clear the FPU, run it until
// done or timeout, then return the result with a per-requester done pulse.
module fpu_sched #(
   parameter int TIMEOUT = 512,
   parameter int CW      = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [1:0]  op0,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic        req1,
   input  logic [1:0]  op1,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] res,
   output logic        err,
   output logic        busy,
   output logic        fpu_clr,
   output logic        fpu_start,
   output logic [1:0]  fpu_op,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   input  logic [31:0] fpu_r,
   input  logic        fpu_done
);
   import fpu_sched_pkg::*;

   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state;
   logic          id;
   logic          rr;
   logic [CW-1:0] cnt;
   logic          arb_id;
   logic          arb_valid;
   logic [1:0]    win_op;
   logic [31:0]   win_a;
   logic [31:0]   win_b;

   fpu_rr_arb2 u_arb (
      .req0  (req0),
      .req1  (req1),
      .rr    (rr),
      .id    (arb_id),
      .valid (arb_valid)
   );

   assign win_op = arb_id ? op1 : op0;
   assign win_a  = arb_id ? a1  : a0;
   assign win_b  = arb_id ? b1  : b0;

   // Scheduler FSM; every output is a register updated on the transition
   // into the state in which it must be visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         id        <= 1'b0;
         rr        <= 1'b0;
         cnt       <= {CW{1'b0}};
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         res       <= 32'h0000_0000;
         err       <= 1'b0;
         busy      <= 1'b0;
         fpu_clr   <= 1'b0;
         fpu_start <= 1'b0;
         fpu_op    <= 2'b00;
         fpu_a     <= 32'h0000_0000;
         fpu_b     <= 32'h0000_0000;
      end else begin
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         fpu_clr <= 1'b0;
         case (state)
            S_IDLE: begin
               if (arb_valid) begin
                  id   <= arb_id;
                  gnt0 <= ~arb_id;
                  gnt1 <= arb_id;
                  busy <= 1'b1;
                  // Illegal ops never touch the FPU, so its operands stay put.
                  if (win_op == OP_ILLEGAL) begin
                     res   <= QNAN;
                     err   <= 1'b1;
                     state <= S_RESP;
                  end else begin
                     fpu_op    <= win_op;
                     fpu_a     <= win_a;
                     fpu_b     <= win_b;
                     fpu_clr   <= 1'b1;
                     fpu_start <= 1'b1;
                     state     <= S_CLR;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            S_CLR: begin
               cnt   <= {CW{1'b0}};
               state <= S_RUN;
            end
            S_RUN: begin
               if (fpu_done) begin
                  res       <= fpu_r;
                  err       <= 1'b0;
                  fpu_start <= 1'b0;
                  state     <= S_RESP;
               end else if (cnt == CNT_LAST) begin
                  res       <= QNAN;
                  err       <= 1'b1;
                  fpu_clr   <= 1'b1;
                  fpu_start <= 1'b0;
                  state     <= S_RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RESP: begin
               done0 <= ~id;
               done1 <= id;
               rr    <= ~id;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy      <= 1'b0;
               fpu_start <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
